// File: rtl/meas_pkg.sv
// Shared types and defaults for the measurement sequencer.
package meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FREQ_GATE,
        FREQ_WAIT,
        DUTY_RUN,
        PUBLISH
    } meas_state_t;

    localparam int MEAS_GATE_CYCLES    = 10_000_000;
    localparam int MEAS_TIMEOUT_CYCLES = 20_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/meas_timer.sv
// Shared phase timer: counts up while enabled, clears on request and
// flags when the count equals the loaded terminal value.
module meas_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/meas_scheduler.sv
// Frequency/duty measurement sequencer with per-phase timeouts and coherent publish.
// Define MEAS_DUTY_EN to include the duty-cycle phase; otherwise duty outputs are tied low.
module meas_scheduler
    import meas_pkg::*;
#(
    parameter int GATE_CYCLES    = MEAS_GATE_CYCLES,
    parameter int TIMEOUT_CYCLES = MEAS_TIMEOUT_CYCLES,
    parameter int FREQ_W         = 32,
    parameter int DUTY_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              restart,
    input  logic              hold,
    output logic              meas_clr,
    output logic              freq_gate,
    input  logic              freq_done,
    input  logic [FREQ_W-1:0] freq_result,
    output logic              duty_start,
    input  logic              duty_done,
    input  logic [DUTY_W-1:0] duty_result,
    output logic [FREQ_W-1:0] freq_out,
    output logic [DUTY_W-1:0] duty_out,
    output logic              result_valid,
    output logic              freq_timeout,
    output logic              duty_timeout,
    output logic              busy
);

    localparam int CNT_W = $clog2(max_int(GATE_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] GATE_TC = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef MEAS_DUTY_EN
    localparam meas_state_t AFTER_FREQ = DUTY_RUN;
`else
    localparam meas_state_t AFTER_FREQ = PUBLISH;
`endif

    meas_state_t       state_q, state_d;
    logic [FREQ_W-1:0] freq_cap_q, freq_cap_d;
    logic              freq_tmo_q, freq_tmo_d;
    logic              publish;
    logic              tc;
    logic [CNT_W-1:0]  tc_val;

    logic              meas_clr_q, freq_gate_q, result_valid_q, busy_q;
    logic [FREQ_W-1:0] freq_out_q;
    logic              freq_timeout_q;

`ifdef MEAS_DUTY_EN
    logic [DUTY_W-1:0] duty_cap_q, duty_cap_d;
    logic              duty_tmo_q, duty_tmo_d;
    logic              duty_start_q;
    logic [DUTY_W-1:0] duty_out_q;
    logic              duty_timeout_q;
`endif

    assign tc_val = (state_q == FREQ_GATE) ? GATE_TC : TMO_TC;

    meas_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_d != state_q),
        .en_i     (state_q != IDLE),
        .tc_val_i (tc_val),
        .tc_o     (tc)
    );

    // A done pulse is checked before the terminal count so a coincident done wins.
    always_comb begin
        state_d    = state_q;
        freq_cap_d = freq_cap_q;
        freq_tmo_d = freq_tmo_q;
`ifdef MEAS_DUTY_EN
        duty_cap_d = duty_cap_q;
        duty_tmo_d = duty_tmo_q;
`endif
        publish    = 1'b0;
        if (!enable || restart) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = FREQ_GATE;
                FREQ_GATE: begin
                    if (tc) state_d = FREQ_WAIT;
                end
                FREQ_WAIT: begin
                    if (freq_done) begin
                        freq_cap_d = freq_result;
                        freq_tmo_d = 1'b0;
                        state_d    = AFTER_FREQ;
                    end else if (tc) begin
                        freq_cap_d = '0;
                        freq_tmo_d = 1'b1;
                        state_d    = AFTER_FREQ;
                    end
                end
`ifdef MEAS_DUTY_EN
                DUTY_RUN: begin
                    if (duty_done) begin
                        duty_cap_d = duty_result;
                        duty_tmo_d = 1'b0;
                        state_d    = PUBLISH;
                    end else if (tc) begin
                        duty_cap_d = '0;
                        duty_tmo_d = 1'b1;
                        state_d    = PUBLISH;
                    end
                end
`endif
                PUBLISH: begin
                    publish = !hold;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decoded from the transition so every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            freq_cap_q     <= '0;
            freq_tmo_q     <= 1'b0;
            meas_clr_q     <= 1'b0;
            freq_gate_q    <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            freq_out_q     <= '0;
            freq_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            freq_cap_q     <= freq_cap_d;
            freq_tmo_q     <= freq_tmo_d;
            meas_clr_q     <= (state_q == IDLE) && (state_d == FREQ_GATE);
            freq_gate_q    <= (state_q == FREQ_GATE) && (state_d != IDLE);
            result_valid_q <= publish;
            busy_q         <= (state_d != IDLE);
            if (publish) begin
                freq_out_q     <= freq_cap_q;
                freq_timeout_q <= freq_tmo_q;
            end
        end
    end

`ifdef MEAS_DUTY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_cap_q     <= '0;
            duty_tmo_q     <= 1'b0;
            duty_start_q   <= 1'b0;
            duty_out_q     <= '0;
            duty_timeout_q <= 1'b0;
        end else begin
            duty_cap_q   <= duty_cap_d;
            duty_tmo_q   <= duty_tmo_d;
            duty_start_q <= (state_q != DUTY_RUN) && (state_d == DUTY_RUN);
            if (publish) begin
                duty_out_q     <= duty_cap_q;
                duty_timeout_q <= duty_tmo_q;
            end
        end
    end

    assign duty_start   = duty_start_q;
    assign duty_out     = duty_out_q;
    assign duty_timeout = duty_timeout_q;
`else
    logic unused_duty;
    assign unused_duty  = ^{duty_done, duty_result};
    assign duty_start   = 1'b0;
    assign duty_out     = '0;
    assign duty_timeout = 1'b0;
`endif

    assign meas_clr     = meas_clr_q;
    assign freq_gate    = freq_gate_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign freq_out     = freq_out_q;
    assign freq_timeout = freq_timeout_q;

endmodule

// File: tb/tb_meas_scheduler.sv
// Self-checking bench for meas_scheduler: table vectors, hand-written corner
// sequences and randomized cycles against a cycle-schedule reference model.
module tb_meas_scheduler;

    localparam int G  = 100;
    localparam int T  = 50;
    localparam int FW = 32;
    localparam int DW = 16;
`ifdef MEAS_DUTY_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, enable, restart, hold;
    logic          freq_done, duty_done;
    logic [FW-1:0] freq_result;
    logic [DW-1:0] duty_result;
    logic          meas_clr, freq_gate, duty_start, result_valid;
    logic          freq_timeout, duty_timeout, busy;
    logic [FW-1:0] freq_out;
    logic [DW-1:0] duty_out;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    logic [FW-1:0] pubFreq;
    logic [DW-1:0] pubDuty;
    bit            pubFtmo, pubDtmo;

    typedef struct {
        int            fd;
        int            dd;
        logic [FW-1:0] fres;
        logic [DW-1:0] dres;
        bit            hl;
        logic [FW-1:0] expFreq;
        logic [DW-1:0] expDuty;
        bit            expFtmo;
        bit            expDtmo;
    } vec_t;

    vec_t vecs[6];

    meas_scheduler #(
        .GATE_CYCLES    (G),
        .TIMEOUT_CYCLES (T),
        .FREQ_W         (FW),
        .DUTY_W         (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .restart      (restart),
        .hold         (hold),
        .meas_clr     (meas_clr),
        .freq_gate    (freq_gate),
        .freq_done    (freq_done),
        .freq_result  (freq_result),
        .duty_start   (duty_start),
        .duty_done    (duty_done),
        .duty_result  (duty_result),
        .freq_out     (freq_out),
        .duty_out     (duty_out),
        .result_valid (result_valid),
        .freq_timeout (freq_timeout),
        .duty_timeout (duty_timeout),
        .busy         (busy)
    );

    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input bit eClr, input bit eGate, input bit eDs,
                               input bit eRv, input bit eBusy);
        chk("meas_clr", meas_clr, eClr);
        chk("freq_gate", freq_gate, eGate);
        chk("duty_start", duty_start, eDs);
        chk("result_valid", result_valid, eRv);
        chk("busy", busy, eBusy);
        chk("freq_out", freq_out, pubFreq);
        chk("duty_out", duty_out, pubDuty);
        chk("freq_timeout", freq_timeout, pubFtmo);
        chk("duty_timeout", duty_timeout, pubDtmo);
    endtask

    // One measurement cycle starting at the meas_clr cycle (k=0).
    // fd/dd: cycle index of the done pulse inside FREQ_WAIT/DUTY_RUN; >= T means no done.
    // abortKind: 0 none, 1 enable drop, 2 restart, 3 async reset, applied at cycle abortAt.
    task automatic applyStimulus(input int fd, input int dd, input logic [FW-1:0] fres,
                                 input logic [DW-1:0] dres, input bit hl, input bit spur,
                                 input int abortKind, input int abortAt);
        int fw, dr, len;
        bit inDuty;
        logic [FW-1:0] ef;
        logic [DW-1:0] ed;
        bit eft, edt;
        fw  = (fd < T) ? fd + 1 : T;
        ef  = (fd < T) ? fres : '0;
        eft = (fd >= T);
        dr  = DUTY_EN ? ((dd < T) ? dd + 1 : T) : 0;
        ed  = (DUTY_EN && dd < T) ? dres : '0;
        edt = DUTY_EN && (dd >= T);
        len = G + fw + dr + 1;
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            cyc++;
            if (abortKind != 0 && k == abortAt + 1) begin
                checkOutput(0, 0, 0, 0, 0);
                freq_done = 1'b0;
                duty_done = 1'b0;
                restart   = 1'b0;
                if (abortKind == 1) begin
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        cyc++;
                        checkOutput(0, 0, 0, 0, 0);
                    end
                    enable = 1'b1;
                end
                return;
            end
            if (k == len && !hl) begin
                pubFreq = ef;
                pubDuty = ed;
                pubFtmo = eft;
                pubDtmo = edt;
            end
            checkOutput(k == 0, k >= 1 && k <= G, DUTY_EN && k == G + fw,
                        k == len && !hl, k < len);
            inDuty      = DUTY_EN && k >= G + fw && k < G + fw + dr;
            hold        = hl;
            freq_done   = 1'b0;
            duty_done   = 1'b0;
            freq_result = $urandom();
            duty_result = DW'($urandom());
            if (fd < T && k == G + fd) begin
                freq_done   = 1'b1;
                freq_result = fres;
            end else if (spur && (k < G || k == len) && $urandom_range(0, 7) == 0) begin
                freq_done = 1'b1;
            end
            if (inDuty && dd < T && k == G + fw + dd) begin
                duty_done   = 1'b1;
                duty_result = dres;
            end else if (spur && !inDuty && $urandom_range(0, 7) == 0) begin
                duty_done = 1'b1;
            end
            if (abortKind != 0 && k == abortAt) begin
                if (abortKind == 1) begin
                    enable = 1'b0;
                end else if (abortKind == 2) begin
                    restart = 1'b1;
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                    pubFreq = '0;
                    pubDuty = '0;
                    pubFtmo = 1'b0;
                    pubDtmo = 1'b0;
                    checkOutput(0, 0, 0, 0, 0);
                    freq_done = 1'b0;
                    duty_done = 1'b0;
                    @(negedge clk);
                    cyc++;
                    checkOutput(0, 0, 0, 0, 0);
                    rst_n = 1'b1;
                    return;
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{3, 4, 1234, 5000, 1'b0, 1234, 5000, 1'b0, 1'b0};
        vecs[1] = '{60, 2, 777, 4200, 1'b0, 0, 4200, 1'b1, 1'b0};
        vecs[2] = '{T - 1, 5, 31337, 100, 1'b0, 31337, 100, 1'b0, 1'b0};
        vecs[3] = '{1, 55, 42, 9999, 1'b0, 42, 0, 1'b0, 1'b1};
        vecs[4] = '{0, 0, 999, 1, 1'b1, 42, 0, 1'b0, 1'b1};
        vecs[5] = '{2, T - 1, 555, 2500, 1'b0, 555, 2500, 1'b0, 1'b0};

        rst_n       = 1'b1;
        enable      = 1'b0;
        restart     = 1'b0;
        hold        = 1'b0;
        freq_done   = 1'b0;
        duty_done   = 1'b0;
        freq_result = '0;
        duty_result = '0;
        pubFreq     = '0;
        pubDuty     = '0;
        pubFtmo     = 1'b0;
        pubDtmo     = 1'b0;

        #5 rst_n = 1'b0;
        #10 checkOutput(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            checkOutput(0, 0, 0, 0, 0);
        end
        enable = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].fd, vecs[v].dd, vecs[v].fres, vecs[v].dres,
                          vecs[v].hl, 1'b0, 0, 0);
            chk("tbl_freq_out", freq_out, vecs[v].expFreq);
            chk("tbl_duty_out", duty_out, DUTY_EN ? vecs[v].expDuty : '0);
            chk("tbl_freq_timeout", freq_timeout, vecs[v].expFtmo);
            chk("tbl_duty_timeout", duty_timeout, DUTY_EN ? vecs[v].expDtmo : 1'b0);
        end

        applyStimulus(3, 4, 111, 222, 1'b0, 1'b0, 1, 40);
        applyStimulus(3, 4, 333, 444, 1'b0, 1'b0, 2, DUTY_EN ? G + 4 + 4 : G + 3);
        applyStimulus(3, 4, 1234, 5000, 1'b0, 1'b0, 0, 0);
        applyStimulus(3, 4, 666, 888, 1'b0, 1'b0, 3, 30);

        for (int r = 0; r < 20; r++) begin
            applyStimulus($urandom_range(0, T + 9), $urandom_range(0, T + 9), $urandom(),
                          DW'($urandom()), $urandom_range(0, 4) == 0, 1'b1, 0, 0);
        end

        enable = 1'b0;
        @(negedge clk);
        cyc++;
        checkOutput(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
